frequency_generator: RTL and testbench
======================================

# frequency_generator

Programmable square-wave source: accepts a target frequency in Hz, converts it by serial division into a half-period count of `clk` cycles, and drives a 50 % duty-cycle output on `freqout`. Sits on the stimulus side of the measurement chain. Its 24-bit Hz word and per-second clock-count parameter match the format used by the board's frequency measurement path, so the same values loop back.

## Interface
Parameters:
- `SecondCount`, 8001800: number of `clk` cycles in one second; must fit 24 bits.
- `Width`, 24: width of frequency words.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  output enable; low forces `freqout` low.
- `freq_set`  in  24  requested frequency in Hz.
- `set_valid`  in  1  request strobe; `freq_set` sampled when `set_valid && set_ready`.
- `set_ready`  out  1  high when a new request can be accepted.
- `freqout`  out  1  generated square wave.
- `active_freq`  out  24  Hz value currently driving `freqout`.
- `updated`  out  1  one-cycle pulse when a new setting takes effect.

## Operation
- Half-period: H = floor(SecondCount / (2·F)), computed by restoring serial division. Divisor is 25 bits, quotient 24 bits.
- Clamps:
  - F = 0 → H = 0, meaning stopped: `freqout` held low.
  - F ≠ 0 and quotient 0 → H = 1, giving clk/2.
- Control FSM states: IDLE, DIVIDE, COMMIT.
  - IDLE: `set_ready`=1. Handshake latches F and moves to DIVIDE.
  - DIVIDE: exactly 24 iterations, one quotient bit per cycle, MSB first. `set_ready`=0.
  - COMMIT: apply clamps, write pending H and F, set the pending flag, return to IDLE.
- Output generator: half-period counter `cnt` runs 0..H−1. At `cnt == H−1`, `freqout` toggles and `cnt` resets to 0.
- Pending-setting application:
  - Applied only at a toggle boundary, so no runt pulses.
  - Applied immediately if the generator is stopped (active H = 0) or `enable` = 0.
  - On apply: `active_freq` ← F, `cnt` ← 0, `updated` pulses for one cycle, pending flag clears.
- `enable`=0: `freqout`=0 and `cnt`=0. On `enable` rising, the first `freqout` rise occurs after H cycles.
- A new request accepted while a previous setting is still pending: the newer COMMIT overwrites the pending H/F. Only the last one is applied, with one `updated` pulse.
- `freq_set` changes outside the handshake are ignored.

## Timing
- Reset values: `freqout`=0, `set_ready`=1, `active_freq`=0, `updated`=0, active H=0, pending flag=0, FSM=IDLE, `cnt`=0.
- Handshake at cycle t:
  - DIVIDE runs t+1..t+24.
  - COMMIT occurs at t+25.
  - `set_ready` is high again at t+26.
  - Earliest apply (stopped generator) at t+26, with `updated` high during t+26.
- Running generator: apply occurs on the first toggle cycle at or after t+26. Latency is at most 26 + H_old cycles.
- Output period is 2H cycles. `freqout` is registered, so there is no combinational path from inputs.
- Reset asserted mid-DIVIDE: all state returns to reset values immediately. The in-flight request is discarded and no `updated` pulse is produced.
- Same-cycle COMMIT and toggle: the pending value is applied on the next toggle, never in the same cycle as COMMIT.

## Structure
- Package `freqgen_pkg`: FSM state enum (IDLE, DIVIDE, COMMIT), `DIV_STEPS` = 24, and the frequency word type (`logic [23:0]`).
- Sub-module `serial_divider`:
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient.
  - 24-cycle restoring algorithm; reusable by other blocks.
- Top level contains the FSM, the pending register, and the output counter/toggle.

## Test plan
- Reset, then F=1000 with `enable`=1 → `set_ready` low for 25 cycles; `updated` 26 cycles after handshake; `freqout` period 8000 clk (H=4000), 50 % duty; `active_freq`=1000.
- F=1 → H=4000900; F=4000900 → H=1, clk/2 output; F=5000000 → clamp H=1; `active_freq` reports the requested value in each case.
- Running at F=1000, request F=2000 mid-half-period → no output edge spacing other than 4000 or 2000 cycles; switch lands exactly on a toggle; single `updated`.
- F=0 → `freqout` low indefinitely; a subsequent F=1000 applies at t+26 with no wait for a toggle.
- Two back-to-back requests (1000, then 3000) while a slow period (F=1) is pending → only 3000 applied, one `updated` pulse.
- Assert `rst_n`=0 at cycle 10 of DIVIDE → all outputs return to reset values immediately, `set_ready`=1 after release, no `updated` pulse; toggle `enable` → output low while 0, first rise H cycles after re-enable.

Source files
------------

// File: rtl/freqgen_pkg.sv
// Shared types and constants for the programmable square-wave generator.
package freqgen_pkg;

  localparam int unsigned DIV_STEPS = 24;
  localparam int unsigned FREQ_W    = 24;

  typedef logic [FREQ_W-1:0] freq_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, MSB first.
// The first iteration is folded into the start cycle, so done follows start by Width cycles.
module serial_divider
  import freqgen_pkg::*;
#(
  parameter int unsigned Width = DIV_STEPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Width-1:0] dividend,
  input  logic [Width:0]   divisor,
  output logic             done,
  output logic [Width-1:0] quotient
);

  localparam int unsigned RemW  = Width + 1;
  localparam int unsigned IterW = $clog2(Width + 1);

  logic             busy;
  logic [IterW-1:0] iter;
  logic [Width:0]   rem;
  logic [Width:0]   dvs;
  logic [Width-1:0] dvd;
  logic [Width+1:0] nxt_c;

  // Returns {quotient bit, new remainder}.
  function automatic logic [Width+1:0] div_step(input logic [Width:0] r, input logic b,
                                                input logic [Width:0] d);
    logic [Width+1:0] sh;
    sh = {r, b};
    if (sh >= {1'b0, d}) return {1'b1, RemW'(sh - {1'b0, d})};
    else                 return {1'b0, sh[Width:0]};
  endfunction

  assign nxt_c = start ? div_step('0, dividend[Width-1], divisor)
                       : div_step(rem, dvd[Width-1], dvs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      iter     <= '0;
      rem      <= '0;
      dvs      <= '0;
      dvd      <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        iter     <= IterW'(1);
        rem      <= nxt_c[Width:0];
        dvd      <= {dividend[Width-2:0], 1'b0};
        dvs      <= divisor;
        quotient <= {{(Width-1){1'b0}}, nxt_c[Width+1]};
      end else if (busy) begin
        rem      <= nxt_c[Width:0];
        dvd      <= {dvd[Width-2:0], 1'b0};
        quotient <= {quotient[Width-2:0], nxt_c[Width+1]};
        iter     <= iter + IterW'(1);
        if (iter == IterW'(Width - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/frequency_generator.sv
// Programmable 50% duty square-wave source: Hz request -> half-period via serial division,
// new settings applied only on toggle boundaries (or at once when stopped/disabled).
module frequency_generator
  import freqgen_pkg::*;
#(
  parameter int unsigned SecondCount = 8001800,
  parameter int unsigned Width       = FREQ_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [Width-1:0] freq_set,
  input  logic             set_valid,
  output logic             set_ready,
  output logic             freqout,
  output logic [Width-1:0] active_freq,
  output logic             updated
);

  state_e           state;
  logic [Width-1:0] f_lat;
  logic [Width-1:0] quo;
  logic             div_done;
  logic             pend;
  logic [Width-1:0] pend_h;
  logic [Width-1:0] pend_f;
  logic [Width-1:0] act_h;
  logic [Width-1:0] cnt;

  logic             hs_c;
  logic             commit_c;
  logic [Width-1:0] h_clamp_c;
  logic             tick_c;
  logic             apply_c;
  logic             stop_c;

  assign hs_c      = set_valid && set_ready;
  assign commit_c  = (state == COMMIT);
  assign h_clamp_c = (f_lat == '0) ? '0 : ((quo == '0) ? Width'(1) : quo);
  assign tick_c    = enable && (act_h != '0) && (cnt == act_h - Width'(1));
  // A commit in this cycle blocks apply so the fresh value waits for the next boundary.
  assign apply_c   = pend && !commit_c && (!enable || (act_h == '0) || tick_c);
  assign stop_c    = !enable || (apply_c ? (pend_h == '0) : (act_h == '0));

  serial_divider #(.Width(Width)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (hs_c),
    .dividend (Width'(SecondCount)),
    .divisor  ({freq_set, 1'b0}),
    .done     (div_done),
    .quotient (quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      set_ready <= 1'b1;
      f_lat     <= '0;
    end else begin
      case (state)
        IDLE: if (hs_c) begin
          state     <= DIVIDE;
          set_ready <= 1'b0;
          f_lat     <= freq_set;
        end
        DIVIDE: if (div_done) state <= COMMIT;
        COMMIT: begin
          state     <= IDLE;
          set_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          set_ready <= 1'b1;
        end
      endcase
    end
  end

  // Pending setting: a newer commit simply overwrites an unapplied one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= 1'b0;
      pend_h <= '0;
      pend_f <= '0;
    end else if (commit_c) begin
      pend   <= 1'b1;
      pend_h <= h_clamp_c;
      pend_f <= f_lat;
    end else if (apply_c) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_h       <= '0;
      active_freq <= '0;
      cnt         <= '0;
      freqout     <= 1'b0;
      updated     <= 1'b0;
    end else begin
      updated <= apply_c;
      if (apply_c) begin
        act_h       <= pend_h;
        active_freq <= pend_f;
      end
      if (stop_c) begin
        freqout <= 1'b0;
        cnt     <= '0;
      end else if (tick_c) begin
        freqout <= ~freqout;
        cnt     <= '0;
      end else if (apply_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + Width'(1);
      end
    end
  end

endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench for frequency_generator: vector table, directed corner sequences, random retunes.
module tb_frequency_generator;

  localparam int unsigned SECOND = 8001800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [23:0] freq_set;
  logic        set_valid;
  logic        set_ready;
  logic        freqout;
  logic [23:0] active_freq;
  logic        updated;

  always #5 clk = ~clk;

  frequency_generator #(.SecondCount(SECOND), .Width(24)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .freq_set    (freq_set),
    .set_valid   (set_valid),
    .set_ready   (set_ready),
    .freqout     (freqout),
    .active_freq (active_freq),
    .updated     (updated)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge/update timestamps, indexed by the rising clock edge that caused them.
  logic fo_prev = 1'b0;
  int   edge_q[$];
  int   upd_q[$];
  always @(negedge clk) begin
    if (freqout !== fo_prev) begin
      edge_q.push_back(cyc);
      fo_prev = freqout;
    end
    if (updated === 1'b1) upd_q.push_back(cyc);
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    int unsigned f;
    int unsigned h;
  } vec_t;
  vec_t tbl[8];

  function automatic int unsigned model_h(int unsigned f);
    int unsigned q;
    if (f == 0) return 0;
    q = SECOND / (2 * f);
    return (q == 0) ? 1 : q;
  endfunction

  task automatic check(string nm, longint act, longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_edges(int n, int budget, output bit ok);
    int k = 0;
    while (edge_q.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (edge_q.size() >= n);
  endtask

  task automatic send(int unsigned f, output int t);
    int k = 0;
    while (!set_ready && k < 200) begin
      step();
      k++;
    end
    check("ready_before_req", set_ready, 1);
    freq_set  = f[23:0];
    set_valid = 1'b1;
    step();
    t         = cyc;
    set_valid = 1'b0;
    freq_set  = 24'($urandom);
  endtask

  // Request against a stopped or disabled generator: applies 26 cycles after the handshake.
  task automatic req_stopped(string tag, int unsigned f, output int t);
    int n = 0;
    send(f, t);
    while (!set_ready && n < 100) begin
      n++;
      step();
    end
    check({tag, "_ready_low"}, n, 25);
    check({tag, "_no_early_upd"}, updated, 0);
    step();
    check({tag, "_upd"}, updated, 1);
    check({tag, "_freq"}, active_freq, f);
    step();
    check({tag, "_upd_pulse"}, updated, 0);
  endtask

  task automatic enable_and_measure(string tag, int unsigned h, int n);
    int e;
    bit ok;
    edge_q.delete();
    enable = 1'b1;
    e      = cyc;
    if (h == 0 || h > 5000) begin
      steps(100);
      check({tag, "_no_edges"}, edge_q.size(), 0);
      check({tag, "_low"}, freqout, 0);
    end else begin
      wait_edges(n, n * h + 50, ok);
      check({tag, "_edges_seen"}, ok, 1);
      if (ok) begin
        check({tag, "_first_rise"}, edge_q[0] - e, h);
        for (int i = 1; i < n; i++) check({tag, "_half"}, edge_q[i] - edge_q[i-1], h);
      end
    end
  endtask

  // Retune a running generator; the switch must land on its next toggle at or after t+26.
  task automatic run_switch(string tag, int unsigned fnew, int unsigned hold, int unsigned hnew,
                            int off);
    int t, r0, s, nu, k, diff, pred, bad, found, post;
    bit ok;
    r0 = edge_q[edge_q.size()-1];
    s  = edge_q.size() - 1;
    nu = upd_q.size();
    steps(off);
    send(fnew, t);
    diff = t + 26 - r0;
    k    = (diff + int'(hold) - 1) / int'(hold);
    if (k < 1) k = 1;
    pred = r0 + k * int'(hold);
    k = 0;
    while (upd_q.size() == nu && k < 26 + int'(hold) + 60) begin
      step();
      k++;
    end
    check({tag, "_upd_seen"}, upd_q.size(), nu + 1);
    if (upd_q.size() > nu) begin
      check({tag, "_upd_at"}, upd_q[nu], pred);
      check({tag, "_latency_ok"}, (upd_q[nu] - t) <= 26 + int'(hold), 1);
    end
    check({tag, "_freq"}, active_freq, fnew);
    if (hnew != 0) begin
      wait_edges(edge_q.size() + 2, 2 * int'(hnew) + 50, ok);
      check({tag, "_post_edges"}, ok, 1);
      found = 0;
      bad   = 0;
      for (int i = s; i < edge_q.size(); i++) if (edge_q[i] == pred) found = 1;
      for (int i = s + 1; i < edge_q.size(); i++)
        if (edge_q[i] - edge_q[i-1] != int'(hold) && edge_q[i] - edge_q[i-1] != int'(hnew)) bad++;
      check({tag, "_edge_at_apply"}, found, 1);
      check({tag, "_spacing"}, bad, 0);
      check({tag, "_new_half"}, edge_q[edge_q.size()-1] - edge_q[edge_q.size()-2], hnew);
    end else begin
      steps(200);
      post = 0;
      for (int i = 0; i < edge_q.size(); i++) if (edge_q[i] > pred) post++;
      check({tag, "_stopped_low"}, freqout, 0);
      check({tag, "_stopped_edges"}, post, 0);
    end
    check({tag, "_single_upd"}, upd_q.size(), nu + 1);
  endtask

  initial begin
    int t, n0, hi;
    int unsigned hold, f, hn;
    bit ok;

    tbl[0] = '{1000, 4000};
    tbl[1] = '{1, 4000900};
    tbl[2] = '{4000900, 1};
    tbl[3] = '{5000000, 1};
    tbl[4] = '{2000, 2000};
    tbl[5] = '{0, 0};
    tbl[6] = '{3000, 1333};
    tbl[7] = '{7, 571557};

    rst_n     = 1'b0;
    enable    = 1'b0;
    set_valid = 1'b0;
    freq_set  = '0;
    steps(3);
    check("rst_freqout", freqout, 0);
    check("rst_ready", set_ready, 1);
    check("rst_active", active_freq, 0);
    check("rst_updated", updated, 0);
    rst_n = 1'b1;
    steps(2);

    // Vector table: each setting applied while disabled, then measured after enable rises.
    foreach (tbl[i]) begin
      enable = 1'b0;
      req_stopped($sformatf("tbl%0d", i), tbl[i].f, t);
      enable_and_measure($sformatf("tbl%0d", i), tbl[i].h, 3);
      enable = 1'b0;
      step();
      check($sformatf("tbl%0d_disable_low", i), freqout, 0);
    end

    // Retune 1000 Hz -> 2000 Hz mid half-period.
    req_stopped("a_base", 1000, t);
    edge_q.delete();
    enable = 1'b1;
    wait_edges(1, 4100, ok);
    check("a_running", ok, 1);
    run_switch("a_switch", 2000, 4000, 2000, 1000);

    // Stop via F=0, then a new request applies without waiting for a toggle.
    run_switch("b_stop", 0, 2000, 0, 300);
    req_stopped("b_restart", 1000, t);
    edge_q.delete();
    wait_edges(1, 4100, ok);
    check("b_restart_edge", ok, 1);
    if (ok) check("b_restart_rise", edge_q[0], t + 26 + 4000);

    // Random retunes against the arithmetic model.
    hold = 4000;
    for (int i = 0; i < 5; i++) begin
      f  = $urandom_range(400000, 8000);
      hn = model_h(f);
      run_switch($sformatf("rnd%0d", i), f, hold, hn, int'($urandom_range(hold - 1, 0)));
      hold = hn;
    end

    // Two requests while a very slow period holds the pending slot: only the last survives.
    enable = 1'b0;
    step();
    req_stopped("c_slow", 1, t);
    enable = 1'b1;
    n0 = upd_q.size();
    send(1000, t);
    send(3000, t);
    steps(40);
    check("c_pending_held", upd_q.size(), n0);
    check("c_still_slow", active_freq, 1);
    enable = 1'b0;
    step();
    check("c_apply_on_disable", updated, 1);
    check("c_last_wins", active_freq, 3000);
    steps(3);
    check("c_single_upd", upd_q.size(), n0 + 1);
    enable_and_measure("c_run", 1333, 3);

    // Reset in the middle of a division.
    send(2000, t);
    steps(9);
    rst_n = 1'b0;
    #1;
    check("d_rst_freqout", freqout, 0);
    check("d_rst_ready", set_ready, 1);
    check("d_rst_active", active_freq, 0);
    check("d_rst_updated", updated, 0);
    steps(2);
    rst_n = 1'b1;
    n0 = upd_q.size();
    steps(40);
    check("d_no_upd", upd_q.size(), n0);
    check("d_ready_after", set_ready, 1);
    check("d_active_after", active_freq, 0);

    // Enable toggling: low while disabled, first rise H cycles after re-enable.
    req_stopped("d_post", 1000, t);
    steps(500);
    enable = 1'b0;
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      hi += int'(freqout);
    end
    check("d_disabled_low", hi, 0);
    enable_and_measure("d_reenable", 4000, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
